riscv_data_stall_bridge: RTL and testbench

- Sits on the core data port, directly upstream of mm_ram, between riscv_core and the RAM model in the core testbench wrapper.
- Injects programmable grant and response latency so core LSU stall paths can be exercised. Address, write data and control pass through unchanged.
- Holds responses in order in a small FIFO, and limits outstanding transactions so that FIFO can never overflow.

---
 rtl/riscv_data_stall_bridge.sv | 129 ++++++++++++
 tb/tb_riscv_data_stall_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_stall_bridge.sv
// riscv_data_stall_bridge: delays grants and responses on the core data port to exercise LSU stalls
module riscv_data_stall_bridge #(
    parameter int DEPTH       = 4,
    parameter int DELAY_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DELAY_WIDTH-1:0]     gnt_delay_i,
    input  logic [DELAY_WIDTH-1:0]     rvalid_delay_i,
    input  logic                       data_req_i,
    input  logic [31:0]                data_addr_i,
    input  logic                       data_we_i,
    input  logic [3:0]                 data_be_i,
    input  logic [31:0]                data_wdata_i,
    input  logic [5:0]                 data_atop_i,
    output logic                       data_gnt_o,
    output logic                       data_rvalid_o,
    output logic [31:0]                data_rdata_o,
    output logic                       ram_req_o,
    output logic [31:0]                ram_addr_o,
    output logic                       ram_we_o,
    output logic [3:0]                 ram_be_o,
    output logic [31:0]                ram_wdata_o,
    output logic [5:0]                 ram_atop_o,
    input  logic                       ram_gnt_i,
    input  logic                       ram_rvalid_i,
    input  logic [31:0]                ram_rdata_i,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state, state_nxt;
    logic [DELAY_WIDTH-1:0] cnt, cnt_nxt;
    logic [CW-1:0]          outstanding, count;
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [31:0]            fifo_data [DEPTH];
    logic [DELAY_WIDTH-1:0] fifo_ctr [DEPTH];
    logic                   full, req, empty, bypass, push, pop;
    logic [DELAY_WIDTH-1:0] push_ctr;

    assign ram_addr_o    = data_addr_i;
    assign ram_we_o      = data_we_i;
    assign ram_be_o      = data_be_i;
    assign ram_wdata_o   = data_wdata_i;
    assign ram_atop_o    = data_atop_i;
    assign outstanding_o = outstanding;

    assign full       = outstanding == CW'(DEPTH);
    assign ram_req_o  = req & rst_ni;
    assign data_gnt_o = ram_req_o & ram_gnt_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        case (state)
            IDLE: if (data_req_i) begin
                if (gnt_delay_i == '0) begin
                    req       = !full;
                    state_nxt = (ram_gnt_i && !full) ? IDLE : WAIT;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = gnt_delay_i - DELAY_WIDTH'(1);
                end
            end
            WAIT: if (!data_req_i) begin
                state_nxt = IDLE;
            end else if (cnt != '0) begin
                cnt_nxt = cnt - DELAY_WIDTH'(1);
            end else begin
                req       = !full;
                state_nxt = (ram_gnt_i && !full) ? IDLE : WAIT;
            end
        endcase
    end

    // an incoming response counts as already aged by one cycle; with M=0 and nothing queued it bypasses the FIFO
    assign empty    = count == '0;
    assign bypass   = empty && ram_rvalid_i && rvalid_delay_i == '0;
    assign pop      = !empty && fifo_ctr[rd_ptr] == '0;
    assign push     = ram_rvalid_i && !bypass;
    assign push_ctr = rvalid_delay_i == '0 ? '0 : rvalid_delay_i - DELAY_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            outstanding   <= '0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            outstanding   <= outstanding + CW'(data_gnt_o) - CW'(data_rvalid_o);
            count         <= count + CW'(push) - CW'(pop);
            data_rvalid_o <= pop || bypass;
            if (pop)
                data_rdata_o <= fifo_data[rd_ptr];
            else if (bypass)
                data_rdata_o <= ram_rdata_i;
            if (pop)
                rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            if (push)
                wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
        end
    end

    // stale slots keep counting down harmlessly; a push always overwrites its slot
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++)
            fifo_ctr[i] <= fifo_ctr[i] == '0 ? '0 : fifo_ctr[i] - DELAY_WIDTH'(1);
        if (push) begin
            fifo_data[wr_ptr] <= ram_rdata_i;
            fifo_ctr[wr_ptr]  <= push_ctr;
        end
    end

    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(state == WAIT && !data_req_i));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ram_rvalid_i && count == CW'(DEPTH) && !pop));
endmodule

// File: tb/tb_riscv_data_stall_bridge.sv
// tb_riscv_data_stall_bridge: directed checks of grant delay, response delay, ordering, outstanding limit and reset
module tb_riscv_data_stall_bridge;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [3:0]  gnt_delay_i = '0, rvalid_delay_i = '0;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic [3:0]  data_be_i = '0;
    logic [5:0]  data_atop_i = '0;
    logic        data_gnt_o, data_rvalid_o, ram_req_o, ram_we_o;
    logic [31:0] data_rdata_o, ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [5:0]  ram_atop_o;
    logic        ram_gnt_i = 1'b0, ram_rvalid_i = 1'b0;
    logic [31:0] ram_rdata_i = '0;
    logic [2:0]  outstanding_o;
    int          n_cmp = 0, n_err = 0;

    riscv_data_stall_bridge #(.DEPTH(4), .DELAY_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .gnt_delay_i(gnt_delay_i), .rvalid_delay_i(rvalid_delay_i),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_atop_i(data_atop_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_atop_o(ram_atop_o),
        .ram_gnt_i(ram_gnt_i), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        tick;
        tick;
        check("rst_gnt", 32'(data_gnt_o), 0);
        check("rst_rvalid", 32'(data_rvalid_o), 0);
        check("rst_rdata", data_rdata_o, 0);
        check("rst_req", 32'(ram_req_o), 0);
        check("rst_out", 32'(outstanding_o), 0);
        rst_ni = 1'b1;

        // N=0, M=0 single read
        tick;
        data_req_i = 1'b1; data_addr_i = 32'h100; ram_gnt_i = 1'b1; #1;
        check("t1_req", 32'(ram_req_o), 1);
        check("t1_gnt", 32'(data_gnt_o), 1);
        check("t1_addr", ram_addr_o, 32'h100);
        tick;
        data_req_i = 1'b0; ram_gnt_i = 1'b0; ram_rvalid_i = 1'b1; ram_rdata_i = 32'hDEADBEEF; #1;
        check("t1_out1", 32'(outstanding_o), 1);
        check("t1_rv_early", 32'(data_rvalid_o), 0);
        tick;
        ram_rvalid_i = 1'b0; #1;
        check("t1_rvalid", 32'(data_rvalid_o), 1);
        check("t1_rdata", data_rdata_o, 32'hDEADBEEF);
        tick;
        check("t1_rv_low", 32'(data_rvalid_o), 0);
        check("t1_hold", data_rdata_o, 32'hDEADBEEF);
        check("t1_out0", 32'(outstanding_o), 0);

        // N=3 grant delay
        gnt_delay_i = 4'd3; ram_gnt_i = 1'b1; data_req_i = 1'b1; data_addr_i = 32'h200;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t2_req%0d", c), 32'(ram_req_o), 32'(c == 3));
            check($sformatf("t2_gnt%0d", c), 32'(data_gnt_o), 32'(c == 3));
            tick;
        end

        // M=5 response delay
        data_req_i = 1'b0; ram_gnt_i = 1'b0; gnt_delay_i = 4'd0;
        ram_rvalid_i = 1'b1; ram_rdata_i = 32'h5555AAAA; rvalid_delay_i = 4'd5; #1;
        check("t3_out1", 32'(outstanding_o), 1);
        check("t3_rv0", 32'(data_rvalid_o), 0);
        tick;
        ram_rvalid_i = 1'b0;
        for (int k = 1; k < 8; k++) begin
            #1;
            check($sformatf("t3_rv%0d", k), 32'(data_rvalid_o), 32'(k == 6));
            if (k == 6) check("t3_rdata", data_rdata_o, 32'h5555AAAA);
            tick;
        end
        check("t3_out0", 32'(outstanding_o), 0);

        // outstanding limit with writes
        rvalid_delay_i = 4'd0; data_req_i = 1'b1; ram_gnt_i = 1'b1; data_we_i = 1'b1;
        data_be_i = 4'hF; data_wdata_i = 32'h12345678; data_atop_i = 6'h2A; data_addr_i = 32'h300;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("t4_gnt%0d", c), 32'(data_gnt_o), 32'(c < 4));
            if (c == 0) begin
                check("t4_ctl", {23'b0, ram_we_o, ram_be_o, ram_atop_o}, {23'b0, 1'b1, 4'hF, 6'h2A});
                check("t4_wdata", ram_wdata_o, 32'h12345678);
            end
            tick;
        end
        check("t4_full", 32'(outstanding_o), 4);
        ram_rvalid_i = 1'b1; ram_rdata_i = 32'h0BADF00D; #1;
        check("t4_gnt_full", 32'(data_gnt_o), 0);
        tick;
        ram_rvalid_i = 1'b0; #1;
        check("t4_rvalid", 32'(data_rvalid_o), 1);
        check("t4_gnt_still", 32'(data_gnt_o), 0);
        tick;
        check("t4_gnt_again", 32'(data_gnt_o), 1);
        tick;
        data_req_i = 1'b0; ram_gnt_i = 1'b0; data_we_i = 1'b0;
        check("t4_refull", 32'(outstanding_o), 4);
        ram_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ram_rdata_i = 32'(i) + 32'hC0; #1;
            if (i > 0) check($sformatf("t4_drain%0d", i), data_rdata_o, 32'(i - 1) + 32'hC0);
            tick;
        end
        ram_rvalid_i = 1'b0;
        check("t4_drain_last", data_rdata_o, 32'hC3);
        tick;
        check("t4_out0", 32'(outstanding_o), 0);

        // ordering: A (M=6) then B (M=0)
        data_req_i = 1'b1; ram_gnt_i = 1'b1;
        tick;
        tick;
        data_req_i = 1'b0; ram_gnt_i = 1'b0;
        ram_rvalid_i = 1'b1; ram_rdata_i = 32'hAAAA0001; rvalid_delay_i = 4'd6;
        tick;
        ram_rdata_i = 32'hBBBB0002; rvalid_delay_i = 4'd0;
        tick;
        ram_rvalid_i = 1'b0;
        for (int k = 2; k < 10; k++) begin
            #1;
            check($sformatf("t5_rv%0d", k), 32'(data_rvalid_o), 32'(k == 7 || k == 8));
            if (k == 7) check("t5_a", data_rdata_o, 32'hAAAA0001);
            if (k == 8) check("t5_b", data_rdata_o, 32'hBBBB0002);
            tick;
        end
        check("t5_out0", 32'(outstanding_o), 0);

        // reset mid-flight
        data_req_i = 1'b1; ram_gnt_i = 1'b1;
        tick;
        tick;
        data_req_i = 1'b0; ram_gnt_i = 1'b0;
        ram_rvalid_i = 1'b1; ram_rdata_i = 32'h77777777; rvalid_delay_i = 4'd5;
        tick;
        ram_rvalid_i = 1'b0; data_req_i = 1'b1; ram_gnt_i = 1'b1; #1;
        check("t6_out2", 32'(outstanding_o), 2);
        check("t6_pre_req", 32'(ram_req_o), 1);
        rst_ni = 1'b0; #1;
        check("t6_req", 32'(ram_req_o), 0);
        check("t6_gnt", 32'(data_gnt_o), 0);
        check("t6_rvalid", 32'(data_rvalid_o), 0);
        check("t6_rdata", data_rdata_o, 0);
        check("t6_out", 32'(outstanding_o), 0);
        data_req_i = 1'b0; ram_gnt_i = 1'b0;
        tick;
        rst_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick;
            check($sformatf("t6_stale%0d", k), 32'(data_rvalid_o), 0);
        end
        check("t6_out_after", 32'(outstanding_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
